// File: rtl/fetch_queue.sv
// Instruction fetch unit: PC, 1-cycle-latency imem reads, DEPTH-entry prefetch FIFO with redirect flush.
// Optional perf counters (perfFetched/perfFlushed) enabled by defining FETCH_QUEUE_PERF_EN.
module fetch_queue #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        INSTR_W  = 32,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [ADDR_W-1:0]  PC_STEP  = ADDR_W'(4)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirectPc,
  output logic               imemRd,
  output logic [ADDR_W-1:0]  imemAddr,
  input  logic [INSTR_W-1:0] imemData,
  output logic               ifValid,
  output logic [INSTR_W-1:0] ifInstr,
  output logic [ADDR_W-1:0]  ifPc,
`ifdef FETCH_QUEUE_PERF_EN
  input  logic               ifReady,
  output logic [31:0]        perfFetched,
  output logic [31:0]        perfFlushed
`else
  input  logic               ifReady
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0]  fetchPc;
  logic [INSTR_W-1:0] instrMem [DEPTH];
  logic [ADDR_W-1:0]  pcMem    [DEPTH];
  logic [PTR_W-1:0]   rdPtr, wrPtr;
  logic [CNT_W-1:0]   count;
  logic               inflight;
  logic [ADDR_W-1:0]  inflightPc;

  logic               pop, push;
  logic [CNT_W-1:0]   occ;

  // occ = slots that will be committed after this cycle's pop; a new read may only
  // issue if it is guaranteed a free slot when its response arrives next cycle.
  always_comb begin
    pop      = (count != '0) && ifReady;
    push     = inflight && !redirect;
    occ      = count + CNT_W'(inflight) - CNT_W'(pop);
    imemRd   = rst_n && !redirect && (occ < CNT_W'(DEPTH));
    imemAddr = fetchPc;
    ifValid  = (count != '0);
    ifInstr  = instrMem[rdPtr];
    ifPc     = pcMem[rdPtr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchPc    <= RESET_PC;
      rdPtr      <= '0;
      wrPtr      <= '0;
      count      <= '0;
      inflight   <= 1'b0;
      inflightPc <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instrMem[i] <= '0;
        pcMem[i]    <= '0;
      end
    end else if (redirect) begin
      fetchPc  <= redirectPc;
      count    <= '0;
      rdPtr    <= wrPtr;
      inflight <= 1'b0;
    end else begin
      if (push) begin
        instrMem[wrPtr] <= imemData;
        pcMem[wrPtr]    <= inflightPc;
        wrPtr           <= wrPtr + PTR_W'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (imemRd) begin
        inflight   <= 1'b1;
        inflightPc <= fetchPc;
        fetchPc    <= fetchPc + PC_STEP;
      end else begin
        inflight <= 1'b0;
      end
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  // On redirect, occ is exactly the queued entries (minus a same-cycle pop) plus the in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perfFetched <= '0;
      perfFlushed <= '0;
    end else begin
      if (push) begin
        perfFetched <= perfFetched + 32'd1;
      end
      if (redirect) begin
        perfFlushed <= perfFlushed + 32'(occ);
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic        ifReady = 1'b0;
  logic [31:0] redirectPc = '0;
  logic [31:0] imemData = '0;
  logic [31:0] imemAddr, ifInstr, ifPc;
  logic        imemRd, ifValid;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perfFetched, perfFlushed;
`endif

  int tests = 0;
  int failed = 0;

  // Reference model state
  logic [31:0] mq[$];
  bit          mInfl;
  logic [31:0] mInflPc, mFetchPc, mFetched, mFlushed;

  logic [97:0] expVec, gotVec;
  logic        gValid, gRd;
  logic [31:0] gPc, gInstr, gAddr;
  int          rdCount;

  fetch_queue #(
    .ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(32'd4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirectPc(redirectPc),
    .imemRd(imemRd), .imemAddr(imemAddr), .imemData(imemData),
    .ifValid(ifValid), .ifInstr(ifInstr), .ifPc(ifPc),
`ifdef FETCH_QUEUE_PERF_EN
    .ifReady(ifReady), .perfFetched(perfFetched), .perfFlushed(perfFlushed)
`else
    .ifReady(ifReady)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: word at A is A+0x1000, one cycle after the strobe; junk otherwise.
  always @(posedge clk) imemData <= imemRd ? imemAddr + 32'h1000 : $urandom;

  task automatic model_reset();
    mq.delete();
    mInfl = 0; mInflPc = '0; mFetchPc = '0; mFetched = '0; mFlushed = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect = 1'b0; ifReady = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a falling edge: drive inputs, capture DUT and model expectations, advance model.
  task automatic cycle(input bit rd, input logic [31:0] rpc, input bit rdy);
    bit eValid, pop, issue;
    int occ;
    redirect = rd; redirectPc = rpc; ifReady = rdy;
    #1;
    eValid = (mq.size() != 0);
    pop    = eValid && rdy;
    occ    = mq.size() + int'(mInfl) - int'(pop);
    issue  = !rd && (occ < int'(DEPTH));
    gValid = ifValid; gPc = ifPc; gInstr = ifInstr; gRd = imemRd; gAddr = imemAddr;
    expVec = {eValid, eValid ? mq[0] : 32'h0, eValid ? mq[0] + 32'h1000 : 32'h0, issue, mFetchPc};
    gotVec = {gValid, gValid ? gPc : 32'h0, gValid ? gInstr : 32'h0, gRd, gAddr};
    if (gRd) rdCount++;
    if (rd) begin
      mFlushed += 32'(occ);
      mq.delete();
      mInfl = 0;
      mFetchPc = rpc;
    end else begin
      if (pop) void'(mq.pop_front());
      if (mInfl) begin mq.push_back(mInflPc); mFetched += 32'd1; end
      if (issue) begin mInfl = 1; mInflPc = mFetchPc; mFetchPc += 32'd4; end
      else mInfl = 0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect = 1'b0; ifReady = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({ifValid, imemRd, imemAddr, ifPc, ifInstr} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
      failed++;
      $display("FAIL reset_values got v=%b rd=%b addr=%h pc=%h instr=%h exp all zero",
               ifValid, imemRd, imemAddr, ifPc, ifInstr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cycle(0, '0, 1);
      tests++;
      if (gotVec !== expVec) begin
        failed++; $display("FAIL stream_model cyc%0d got=%h exp=%h", k, gotVec, expVec);
      end
      if (k >= 2) begin
        tests++;
        if (!(gValid === 1'b1 && gPc === 32'(4 * (k - 2)) && gInstr === 32'(4 * (k - 2)) + 32'h1000)) begin
          failed++;
          $display("FAIL stream_seq cyc%0d got v=%b pc=%h instr=%h exp pc=%h", k, gValid, gPc, gInstr, 4 * (k - 2));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rdCount = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(0, '0, 0);
      tests++;
      if (gotVec !== expVec) begin
        failed++; $display("FAIL stall_model cyc%0d got=%h exp=%h", k, gotVec, expVec);
      end
    end
    tests++;
    if (rdCount != 4) begin
      failed++; $display("FAIL stall_reads got=%0d exp=4", rdCount);
    end
    for (int k = 0; k < 7; k++) begin
      cycle(0, '0, 1);
      tests++;
      if (gotVec !== expVec) begin
        failed++; $display("FAIL b2b_model cyc%0d got=%h exp=%h", k, gotVec, expVec);
      end
      if (k < 5) begin
        tests++;
        if (!(gValid === 1'b1 && gPc === 32'(4 * k))) begin
          failed++; $display("FAIL b2b_seq idx%0d got v=%b pc=%h exp pc=%h", k, gValid, gPc, 4 * k);
        end
      end
    end
  endtask

  task automatic test_redirect_flush();
    int guard;
    logic [31:0] fl0;
    do_reset();
    guard = 0;
    while (!(mq.size() == 2 && mInfl) && guard < 10) begin
      cycle(0, '0, 0);
      guard++;
    end
    tests++;
    if (guard >= 10) begin
      failed++; $display("FAIL flush_setup got timeout exp 2 queued + 1 inflight");
    end
`ifdef FETCH_QUEUE_PERF_EN
    fl0 = perfFlushed;
`else
    fl0 = '0;
`endif
    cycle(1, 32'h40, 0);
    for (int k = 1; k <= 4; k++) begin
      cycle(0, '0, 1);
      tests++;
      if (gotVec !== expVec) begin
        failed++; $display("FAIL flush_model cyc%0d got=%h exp=%h", k, gotVec, expVec);
      end
      if (k == 1) begin
        tests++;
        if (!(gRd === 1'b1 && gAddr === 32'h40 && gValid === 1'b0)) begin
          failed++; $display("FAIL flush_refetch got rd=%b addr=%h v=%b exp 1/40/0", gRd, gAddr, gValid);
        end
      end else if (k == 2) begin
        tests++;
        if (gValid !== 1'b0) begin
          failed++; $display("FAIL flush_gap got v=%b exp 0", gValid);
        end
      end else if (k == 3) begin
        tests++;
        if (!(gValid === 1'b1 && gPc === 32'h40)) begin
          failed++; $display("FAIL flush_target got v=%b pc=%h exp 1/40", gValid, gPc);
        end
      end
    end
`ifdef FETCH_QUEUE_PERF_EN
    tests++;
    if (perfFlushed - fl0 !== 32'd3) begin
      failed++; $display("FAIL flush_perf got=%0d exp=3", perfFlushed - fl0);
    end
`endif
  endtask

  task automatic test_redirect_pop();
    do_reset();
    for (int k = 0; k < 5; k++) cycle(0, '0, 1);
    cycle(1, 32'h200, 1);
    tests++;
    if (gValid !== 1'b1) begin
      failed++; $display("FAIL rpop_handshake got v=%b exp 1", gValid);
    end
    cycle(0, '0, 1);
    tests++;
    if (!(gValid === 1'b0 && gAddr === 32'h200)) begin
      failed++; $display("FAIL rpop_after got v=%b addr=%h exp 0/200", gValid, gAddr);
    end
`ifdef FETCH_QUEUE_PERF_EN
    tests++;
    if (perfFlushed !== mFlushed) begin
      failed++; $display("FAIL rpop_perf got=%0d exp=%0d", perfFlushed, mFlushed);
    end
`endif
  endtask

  task automatic test_wrap();
    logic [31:0] seen[$];
    logic [31:0] want[3];
    want[0] = 32'hFFFF_FFFC; want[1] = 32'h0; want[2] = 32'h4;
    do_reset();
    cycle(0, '0, 1);
    cycle(1, 32'hFFFF_FFFC, 1);
    for (int k = 0; k < 7; k++) begin
      cycle(0, '0, 1);
      tests++;
      if (gotVec !== expVec) begin
        failed++; $display("FAIL wrap_model cyc%0d got=%h exp=%h", k, gotVec, expVec);
      end
      if (gValid) seen.push_back(gPc);
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (seen.size() <= i || seen[i] !== want[i]) begin
        failed++;
        $display("FAIL wrap_seq idx%0d got=%h exp=%h", i, seen.size() > i ? seen[i] : 32'hx, want[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    int guard;
    do_reset();
    guard = 0;
    while (mq.size() != 3 && guard < 10) begin
      cycle(0, '0, 0);
      guard++;
    end
    tests++;
    if (guard >= 10) begin
      failed++; $display("FAIL areset_setup got timeout exp count=3");
    end
    redirect = 1'b0; ifReady = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if (!(ifValid === 1'b0 && imemRd === 1'b0 && imemAddr === 32'h0)) begin
      failed++; $display("FAIL areset_immediate got v=%b rd=%b addr=%h exp 0/0/0", ifValid, imemRd, imemAddr);
    end
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cycle(0, '0, 1);
      tests++;
      if (gotVec !== expVec) begin
        failed++; $display("FAIL areset_restart cyc%0d got=%h exp=%h", k, gotVec, expVec);
      end
    end
  endtask

  task automatic test_random();
    bit rd, rdy;
    logic [31:0] rpc;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rd  = ($urandom_range(0, 11) == 0);
      rpc = $urandom;
      rdy = ($urandom_range(0, 3) != 0);
      cycle(rd, rpc, rdy);
      tests++;
      if (gotVec !== expVec) begin
        failed++; $display("FAIL random_model cyc%0d got=%h exp=%h", k, gotVec, expVec);
      end
    end
`ifdef FETCH_QUEUE_PERF_EN
    tests++;
    if ({perfFetched, perfFlushed} !== {mFetched, mFlushed}) begin
      failed++; $display("FAIL random_perf got=%0d/%0d exp=%0d/%0d", perfFetched, perfFlushed, mFetched, mFlushed);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_to_back();
    test_redirect_flush();
    test_redirect_pop();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
